// File: rtl/asip_pkg.sv
// asip_pkg: opcodes, ALU controls, flag positions and sequencer states shared
// by the decode, sequencer and ALU blocks.
package asip_pkg;
   typedef enum logic [3:0] {OP_MOV = 4'b0000, OP_SUBS = 4'b0001, OP_ADDS = 4'b0100} op_e;
   localparam logic [3:0] ALU_SUB = 4'b0010;
   localparam logic [3:0] ALU_ADD = 4'b0100;
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;
   typedef enum logic [2:0] {S_IDLE, S_A_REQ, S_B_REQ, S_B_LAT, S_EXEC, S_WB} seq_state_e;
   function automatic logic op_supported(input logic [3:0] op);
      return op == OP_MOV || op == OP_SUBS || op == OP_ADDS;
   endfunction
endpackage

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: instruction issue handshake from decode to the sequencer.
interface alu_op_sequencer_if #(
   parameter int REG_ADDR_W = 4,
   parameter int IMM_W      = 16
);
   logic                  valid;
   logic                  ready;
   logic [3:0]            op;
   logic [REG_ADDR_W-1:0] rd;
   logic [REG_ADDR_W-1:0] rn;
   logic [REG_ADDR_W-1:0] rm;
   logic                  imm_sel;
   logic [IMM_W-1:0]      imm;
   logic                  set_flags;
   modport master (output valid, op, rd, rn, rm, imm_sel, imm, set_flags, input ready);
   modport slave  (input valid, op, rd, rn, rm, imm_sel, imm, set_flags, output ready);
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: runs one MOV/SUBS/ADDS instruction through the single
// register-file read port, the external ALU and a one-cycle write-back.
module alu_op_sequencer
   import asip_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 4,
   parameter int IMM_W      = 16,
   parameter int PC_REG     = 15
) (
   input  logic                  clk,
   input  logic                  reset,
   alu_op_sequencer_if.slave     issue,
   output logic [REG_ADDR_W-1:0] rf_read_reg,
   input  logic [DATA_W-1:0]     rf_read_value,
   output logic [3:0]            alu_control,
   output logic [DATA_W-1:0]     alu_a,
   output logic [DATA_W-1:0]     alu_b,
   input  logic [DATA_W-1:0]     alu_result,
   input  logic [3:0]            alu_flags,
   output logic                  rf_write_en,
   output logic [REG_ADDR_W-1:0] rf_write_reg,
   output logic [DATA_W-1:0]     rf_write_value,
   output logic [3:0]            flags,
   output logic                  done,
   output logic                  err
);
   seq_state_e            state;
   logic [3:0]            op_q;
   logic [REG_ADDR_W-1:0] rd_q;
   logic [REG_ADDR_W-1:0] rm_q;
   logic [IMM_W-1:0]      imm_q;
   logic                  imm_sel_q;
   logic                  set_flags_q;
   logic [DATA_W-1:0]     op1;
   logic [3:0]            exec_ctl;
   logic                  pc_dest;

   always_comb begin
      issue.ready = state == S_IDLE;
      exec_ctl    = op_q == OP_ADDS ? ALU_ADD : ALU_SUB;
      pc_dest     = rd_q == REG_ADDR_W'(PC_REG);
   end

   // Strobe outputs default low every cycle and are raised only on the edge into WB.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= S_IDLE;
         op_q           <= '0;
         rd_q           <= '0;
         rm_q           <= '0;
         imm_q          <= '0;
         imm_sel_q      <= 1'b0;
         set_flags_q    <= 1'b0;
         op1            <= '0;
         rf_read_reg    <= '0;
         alu_control    <= '0;
         alu_a          <= '0;
         alu_b          <= '0;
         rf_write_en    <= 1'b0;
         rf_write_reg   <= '0;
         rf_write_value <= '0;
         flags          <= '0;
         done           <= 1'b0;
         err            <= 1'b0;
      end else begin
         rf_write_en <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         case (state)
            S_IDLE: if (issue.valid) begin
               op_q        <= issue.op;
               rd_q        <= issue.rd;
               rm_q        <= issue.rm;
               imm_q       <= issue.imm;
               imm_sel_q   <= issue.imm_sel;
               set_flags_q <= issue.set_flags;
               if (op_supported(issue.op)) begin
                  rf_read_reg <= issue.rn;
                  state       <= S_A_REQ;
               end else begin
                  rf_write_reg <= issue.rd;
                  done         <= 1'b1;
                  err          <= 1'b1;
                  state        <= S_WB;
               end
            end
            S_A_REQ: begin
               if (op_q != OP_MOV && !imm_sel_q) rf_read_reg <= rm_q;
               state <= S_B_REQ;
            end
            S_B_REQ: begin
               op1 <= rf_read_value;
               if (op_q == OP_MOV) begin
                  rf_write_reg   <= rd_q;
                  rf_write_value <= rf_read_value;
                  rf_write_en    <= !pc_dest;
                  done           <= 1'b1;
                  err            <= pc_dest;
                  state          <= S_WB;
               end else if (imm_sel_q) begin
                  alu_a       <= rf_read_value;
                  alu_b       <= DATA_W'(imm_q);
                  alu_control <= exec_ctl;
                  state       <= S_EXEC;
               end else state <= S_B_LAT;
            end
            S_B_LAT: begin
               alu_a       <= op1;
               alu_b       <= rf_read_value;
               alu_control <= exec_ctl;
               state       <= S_EXEC;
            end
            S_EXEC: begin
               if (set_flags_q) flags <= alu_flags;
               rf_write_reg   <= rd_q;
               rf_write_value <= alu_result;
               rf_write_en    <= !pc_dest;
               done           <= 1'b1;
               err            <= pc_dest;
               state          <= S_WB;
            end
            S_WB: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed and random instructions against a per-instruction
// reference model of results, latency, write-back, error and flags.
module tb_alu_op_sequencer;
   import asip_pkg::*;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  rf_read_reg;
   logic [31:0] rf_read_value;
   logic [3:0]  alu_control;
   logic [31:0] alu_a, alu_b, alu_result;
   logic [3:0]  alu_flags;
   logic        rf_write_en;
   logic [3:0]  rf_write_reg;
   logic [31:0] rf_write_value;
   logic [3:0]  flags;
   logic        done, err;
   logic [31:0] rf [16];
   logic [31:0] exp_rf [16];
   logic [3:0]  exp_flags = '0;
   logic [3:0]  exp_ctl = '0;
   logic        poke_en = 1'b0;
   logic [3:0]  poke_idx = '0;
   logic [31:0] poke_val = '0;
   logic [32:0] alu_sum;
   bit          prev_keep = 1'b0;
   int          tests = 0;
   int          fails = 0;

   alu_op_sequencer_if #(.REG_ADDR_W(4), .IMM_W(16)) issue ();

   alu_op_sequencer dut (
      .clk(clk), .reset(reset), .issue(issue),
      .rf_read_reg(rf_read_reg), .rf_read_value(rf_read_value),
      .alu_control(alu_control), .alu_a(alu_a), .alu_b(alu_b),
      .alu_result(alu_result), .alu_flags(alu_flags),
      .rf_write_en(rf_write_en), .rf_write_reg(rf_write_reg), .rf_write_value(rf_write_value),
      .flags(flags), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      rf_read_value <= rf[rf_read_reg];
      if (rf_write_en) rf[rf_write_reg] <= rf_write_value;
      if (poke_en) rf[poke_idx] <= poke_val;
   end

   // Environment ALU: ARM-style carry (no borrow on subtract).
   assign alu_sum    = alu_control == ALU_ADD ? {1'b0, alu_a} + {1'b0, alu_b} : {1'b0, alu_a} - {1'b0, alu_b};
   assign alu_result = alu_sum[31:0];
   assign alu_flags  = {alu_sum[31], alu_sum[31:0] == 32'h0,
                        alu_control == ALU_ADD ? alu_sum[32] : !alu_sum[32],
                        alu_control == ALU_ADD ? (alu_a[31] == alu_b[31] && alu_sum[31] != alu_a[31])
                                               : (alu_a[31] != alu_b[31] && alu_sum[31] != alu_a[31])};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   function automatic logic [3:0] ref_flags(input bit add, input logic [31:0] a, input logic [31:0] b, input logic [31:0] res);
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      longint sr = add ? sa + sb : sa - sb;
      logic c = add ? ({32'h0, a} + {32'h0, b}) > 64'hFFFF_FFFF : a >= b;
      return {res[31], res == 32'h0, c, sr > 64'sd2147483647 || sr < -64'sd2147483648};
   endfunction

   task automatic poke(input logic [3:0] i, input logic [31:0] v);
      poke_en = 1'b1; poke_idx = i; poke_val = v;
      @(negedge clk);
      poke_en = 1'b0;
      exp_rf[i] = v;
   endtask

   task automatic scramble_fields();
      issue.op = 4'($urandom); issue.rd = 4'($urandom); issue.rn = 4'($urandom);
      issue.rm = 4'($urandom); issue.imm_sel = 1'($urandom); issue.imm = 16'($urandom);
      issue.set_flags = 1'($urandom);
   endtask

   // Called at a negedge; returns at the negedge of the done cycle.
   task automatic do_instr(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rn, input logic [3:0] rm,
                           input logic imm_sel, input logic [15:0] imm, input logic sf, input bit keep);
      logic [31:0] a, b, res;
      logic        ok, wr;
      int          lat, exp_lat, n;
      ok      = op == 4'b0000 || op == 4'b0001 || op == 4'b0100;
      a       = exp_rf[rn];
      b       = imm_sel ? {16'h0, imm} : exp_rf[rm];
      res     = op == 4'b0000 ? a : op == 4'b0100 ? a + b : a - b;
      exp_lat = !ok ? 1 : op == 4'b0000 ? 3 : imm_sel ? 4 : 5;
      wr      = ok && rd != 4'd15;
      issue.op = op; issue.rd = rd; issue.rn = rn; issue.rm = rm;
      issue.imm_sel = imm_sel; issue.imm = imm; issue.set_flags = sf; issue.valid = 1'b1;
      n = 0;
      while (!issue.ready && n < 8) begin
         @(negedge clk);
         n++;
         check("done_pulse", done, 0);
      end
      check("ready_idle", issue.ready, 1);
      if (prev_keep) check("b2b_gap", n, 1);
      @(posedge clk);
      lat = 99;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         scramble_fields();
         issue.valid = keep;
         if (done) begin
            lat = k;
            break;
         end
         check("busy_ready", issue.ready, 0);
         check("early_write", rf_write_en, 0);
      end
      check("latency", lat, exp_lat);
      check("err", err, !wr);
      check("write_en", rf_write_en, wr);
      if (wr) begin
         check("write_reg", rf_write_reg, rd);
         check("write_val", rf_write_value, res);
         exp_rf[rd] = res;
      end
      if (ok && op != 4'b0000) begin
         exp_ctl = op == 4'b0100 ? 4'b0100 : 4'b0010;
         check("alu_a", alu_a, a);
         check("alu_b", alu_b, b);
         if (sf) exp_flags = ref_flags(op == 4'b0100, a, b, res);
      end
      check("alu_control", alu_control, exp_ctl);
      check("flags", flags, exp_flags);
      prev_keep = keep;
   endtask

   task automatic reset_checks(input string tag);
      check({tag, "_ready"}, issue.ready, 1);
      check({tag, "_done"}, done, 0);
      check({tag, "_err"}, err, 0);
      check({tag, "_wen"}, rf_write_en, 0);
      check({tag, "_flags"}, flags, 0);
      check({tag, "_ctl"}, alu_control, 0);
      check({tag, "_rdreg"}, rf_read_reg, 0);
      check({tag, "_alu_a"}, alu_a, 0);
   endtask

   initial begin
      logic [3:0] rop;
      int         bad;
      issue.valid = 1'b0;
      scramble_fields();
      repeat (2) @(negedge clk);
      reset_checks("rst");
      reset = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 16; i++) poke(4'(i), $urandom);

      poke(4'd1, 32'd9);
      poke(4'd2, 32'd4);
      do_instr(4'b0001, 4'd3, 4'd1, 4'd2, 1'b0, 16'h0, 1'b1, 1'b0);
      poke(4'd1, 32'hFFFF_FFFF);
      do_instr(4'b0100, 4'd2, 4'd1, 4'd7, 1'b1, 16'h1, 1'b1, 1'b0);
      poke(4'd5, 32'h1234);
      do_instr(4'b0000, 4'd6, 4'd5, 4'd0, 1'b0, 16'h0, 1'b1, 1'b0);
      do_instr(4'b1111, 4'd4, 4'd1, 4'd2, 1'b0, 16'h0, 1'b1, 1'b0);
      do_instr(4'b0100, 4'd15, 4'd3, 4'd2, 1'b0, 16'h0, 1'b1, 1'b0);
      do_instr(4'b0100, 4'd8, 4'd3, 4'd3, 1'b0, 16'h0, 1'b1, 1'b1);
      do_instr(4'b0001, 4'd8, 4'd8, 4'd0, 1'b1, 16'hFFFF, 1'b1, 1'b0);

      // Abort an instruction while it sits in B_LAT.
      @(negedge clk);
      issue.op = 4'b0001; issue.rd = 4'd4; issue.rn = 4'd1; issue.rm = 4'd2;
      issue.imm_sel = 1'b0; issue.set_flags = 1'b1; issue.valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      issue.valid = 1'b0;
      repeat (2) @(negedge clk);
      #1 reset = 1'b0;
      #1 reset_checks("abort");
      exp_flags = '0;
      exp_ctl = '0;
      @(negedge clk);
      reset = 1'b1;
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done || rf_write_en) bad++;
      end
      check("abort_quiet", bad, 0);
      prev_keep = 1'b0;

      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 9))
            0, 1, 2: rop = 4'b0001;
            3, 4, 5: rop = 4'b0100;
            6, 7:    rop = 4'b0000;
            default: rop = 4'($urandom);
         endcase
         if ($urandom_range(0, 7) == 0) poke(4'($urandom), $urandom_range(0, 3));
         do_instr(rop, 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 16'($urandom),
                  1'($urandom), i < 59 && $urandom_range(0, 3) == 0);
      end
      issue.valid = 1'b0;
      repeat (3) @(negedge clk);
      check("final_idle", issue.ready, 1);
      for (int i = 0; i < 16; i++) check("rf_final", rf[i], exp_rf[i]);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
